// File: rtl/box_draw_engine.sv
// box_draw_engine
//   Rasterises one axis-aligned box into a stream of pixels. A start pulse in
//   IDLE latches the box geometry, colour and colour mode. The engine then
//   scans dx (inner) and dy (outer) in raster order. Each on-screen pixel is
//   presented with plot=1 and held until the sink raises ready. Each clipped
//   pixel costs one cycle with plot=0. A one-cycle done pulse ends the box.
//
// Ports
//   clock, resetn       rising-edge clock, synchronous active-low reset
//   start               request to draw one box (sampled in IDLE only)
//   x_in, y_in          box top-left corner
//   w_in, h_in          box size in pixels (zero in either draws nothing)
//   colour_in, mode     colour and mode: 00 fill, 01 flash, 10 erase, 11 checker
//   ready               pixel sink accepts the current pixel
//   x_out, y_out        current pixel coordinate
//   colour_out, plot    current pixel colour and valid flag
//   busy, done          engine active / one-cycle completion pulse
module box_draw_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int S_W      = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [S_W-1:0] w_in,
  input  logic [S_W-1:0] h_in,
  input  logic [C_W-1:0] colour_in,
  input  logic [1:0]     mode,
  input  logic           ready,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  typedef enum logic [1:0] {
    MODE_FILL    = 2'b00,
    MODE_FLASH   = 2'b01,
    MODE_ERASE   = 2'b10,
    MODE_CHECKER = 2'b11
  } mode_t;

  state_t         state;
  state_t         next_state;
  mode_t          mode_r;
  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;
  logic [S_W-1:0] w_r;
  logic [S_W-1:0] h_r;
  logic [C_W-1:0] colour_r;
  logic [S_W-1:0] dx;
  logic [S_W-1:0] dy;

  logic [XS-1:0]  x_sum;
  logic [YS-1:0]  y_sum;
  logic           on_screen;
  logic           last_x;
  logic           last_y;
  logic           step;

  // One extra bit on each sum so that wrap-around past the coordinate width
  // is seen as off-screen rather than aliasing back onto the left/top edge.
  assign x_sum     = {1'b0, x_r} + XS'(dx);
  assign y_sum     = {1'b0, y_r} + YS'(dy);
  assign on_screen = (x_sum < XS'(SCREEN_W)) && (y_sum < YS'(SCREEN_H));
  assign last_x    = (dx == w_r - S_W'(1));
  assign last_y    = (dy == h_r - S_W'(1));
  // Clipped pixels advance regardless of the sink.
  assign step      = (state == DRAW) && (!on_screen || ready);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (w_in != '0 && h_in != '0) ? DRAW : DONE;
        end
      end
      DRAW: begin
        if (step && last_x && last_y) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_r      <= '0;
      y_r      <= '0;
      w_r      <= '0;
      h_r      <= '0;
      colour_r <= '0;
      mode_r   <= MODE_FILL;
      dx       <= '0;
      dy       <= '0;
    end else begin
      if (state == IDLE && start) begin
        x_r      <= x_in;
        y_r      <= y_in;
        w_r      <= w_in;
        h_r      <= h_in;
        colour_r <= colour_in;
        mode_r   <= mode_t'(mode);
        dx       <= '0;
        dy       <= '0;
      end else if (step) begin
        if (last_x) begin
          dx <= '0;
          dy <= dy + S_W'(1);
        end else begin
          dx <= dx + S_W'(1);
        end
      end
    end
  end

  // Outputs come only from state and latched registers, so they hold
  // naturally while the counters are stalled by ready=0.
  always_comb begin
    x_out = x_sum[X_W-1:0];
    y_out = y_sum[Y_W-1:0];
    plot  = (state == DRAW) && on_screen;
    busy  = (state != IDLE);
    done  = (state == DONE);
    unique case (mode_r)
      MODE_FILL:    colour_out = colour_r;
      MODE_FLASH:   colour_out = '1;
      MODE_ERASE:   colour_out = '0;
      MODE_CHECKER: colour_out = (dx[0] ^ dy[0]) ? '1 : colour_r;
      default:      colour_out = colour_r;
    endcase
  end

endmodule

// File: doc/box_draw_engine.md
BOX_DRAW_ENGINE -- requirements
Module: box_draw_engine

Interface
REQ-001 The block SHALL take these parameters:
- X_W, default 8, x coordinate width.
- Y_W, default 7, y coordinate width.
- C_W, default 3, colour width.
- S_W, default 4, box size width (max 2^S_W-1 pixels per side).
- SCREEN_W, default 160, visible columns.
- SCREEN_H, default 120, visible rows.

REQ-002 The block SHALL have these ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request to draw one box.
- x_in  in  X_W  box left column.
- y_in  in  Y_W  box top row.
- w_in  in  S_W  box width in pixels.
- h_in  in  S_W  box height in pixels.
- colour_in  in  C_W  box colour.
- mode  in  2  colour mode: 00 fill, 01 flash, 10 erase, 11 checker.
- ready  in  1  pixel sink accepts the current pixel.
- x_out  out  X_W  pixel column.
- y_out  out  Y_W  pixel row.
- colour_out  out  C_W  pixel colour.
- plot  out  1  current pixel is valid.
- busy  out  1  engine not idle.
- done  out  1  one-cycle completion pulse.

REQ-003 Reset SHALL be resetn, synchronous, active-low; clock SHALL be clock.

Function
REQ-004 The FSM SHALL have three states, IDLE, DRAW and DONE, and SHALL reset to IDLE.
REQ-005 In IDLE, start=1 SHALL latch x_in, y_in, w_in, h_in, colour_in and mode, and clear the dx/dy counters.
- If w_in and h_in are both nonzero, the next state SHALL be DRAW.
- Otherwise the next state SHALL be DONE.
REQ-006 start SHALL be ignored in DRAW and DONE; latched values SHALL stay stable for the whole draw.
REQ-007 In DRAW, x_out SHALL equal x+dx and y_out SHALL equal y+dy, truncated to X_W/Y_W.
REQ-008 The scan order SHALL be raster order: dx is the inner loop (0..w-1) and dy is the outer loop (0..h-1).
REQ-009 A pixel SHALL be on-screen iff the (X_W+1)-bit sum x+dx < SCREEN_W and the (Y_W+1)-bit sum y+dy < SCREEN_H; overflow counts as off-screen.
REQ-010 On-screen pixel: plot=1, and the counter SHALL advance only on a cycle with ready=1. While ready=0, x_out, y_out, colour_out and plot SHALL hold.
REQ-011 Off-screen pixel: plot=0, and the counter SHALL advance unconditionally (clipped pixels cost one cycle, ignoring ready).
REQ-012 colour_out SHALL depend on the latched mode:
- fill: latched colour.
- flash: all ones.
- erase: all zeros.
- checker: latched colour when (dx^dy)[0]=0, otherwise all ones.
REQ-013 When the pixel at dx=w-1, dy=h-1 advances, the next state SHALL be DONE.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in DRAW and DONE and 0 in IDLE; plot SHALL be 0 outside DRAW.
REQ-016 Latency: with start sampled at edge n and ready held high, the first pixel SHALL be presented in cycle n+1, and done SHALL be high in cycle n+1+w*h.
REQ-017 A box with w=1, h=1 SHALL produce exactly one pixel.
REQ-018 Outputs SHALL be registered or derived only from state and latched registers, with no combinational path from start to outputs.

Reset
REQ-019 resetn=0 at any edge, including mid-DRAW, SHALL force the following, and the aborted box SHALL not resume:
- state=IDLE;
- dx=dy=0;
- latched x, y and colour cleared to 0, latched mode cleared to fill;
- plot=0, busy=0, done=0;
- x_out=0, y_out=0, colour_out=0.
REQ-020 The first start after reset release SHALL be honoured normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Fill: x=10, y=20, w=h=4, colour=3'b100, mode=00, ready=1 -> 16 plots, (10,20),(11,20)..(13,20),(10,21)..(13,23), all colour 100; done one cycle, 17 cycles after start.
- Backpressure: same box with ready toggling 1/0 -> exactly 16 accepted plots in the same order; outputs stable while ready=0; done after the 16th acceptance.
- Clipping: x=158, y=118, w=h=4 -> plots only at (158,118),(159,118),(158,119),(159,119); done 17 cycles after start with ready=1.
- Zero size: w=0, h=5, start -> no plot, busy=1 for one cycle, done pulse on the cycle after start.
- Modes: 2x2 box in checker mode, colour=3'b010 -> colours 010, 111, 111, 010; flash -> 111 ×4; erase -> 000 ×4.
- Abort: resetn=0 after the 5th pixel of a 4x4 box, then start a new 1x1 box -> no further pixels from the first box; exactly one plot for the new box; a start pulsed during DRAW is ignored.
